// File: rtl/unidade_controle_drone_pkg.sv
// Shared definitions for the drone game controller: 4-bit state codes
// reused by the FSM and by any debug or HEX display decoder.
package unidade_controle_drone_pkg;

  typedef enum logic [3:0] {
    ST_INICIAL  = 4'h0,
    ST_RESTAURA = 4'h1,
    ST_ESC_MODO = 4'h2,
    ST_ESC_VIDA = 4'h3,
    ST_ESC_MAPA = 4'h4,
    ST_PREPARA  = 4'h5,
    ST_ESPERA   = 4'h6,
    ST_CHECA    = 4'h7,
    ST_VERIFICA = 4'h8,
    ST_GANHOU   = 4'h9,
    ST_PERDEU   = 4'hA
  } estado_t;

endpackage

// File: rtl/unidade_controle_drone_edge_detector.sv
// Rising-edge detector: one-cycle pulse when sinal goes 0 -> 1.
// Synchronous active-high reset clears the history register.
module edge_detector (
  input  logic clock,
  input  logic reset,
  input  logic sinal,
  output logic pulso
);

  logic sinal_q;

  always_ff @(posedge clock) begin
    if (reset) sinal_q <= 1'b0;
    else       sinal_q <= sinal;
  end

  assign pulso = sinal & ~sinal_q;

endmodule

// File: rtl/unidade_controle_drone.sv
// Moore controller for one drone game: map restore, menus, move loop, win/loss.
// All datapath strobes are decoded from the current state; db_estado exposes it.
module unidade_controle_drone
  import unidade_controle_drone_pkg::*;
#(
  parameter int USA_TIMEOUT = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       confirma,
  input  logic       borda_movimento,
  input  logic       timeout,
  input  logic       colisao,
  input  logic       fim_mapa,
  input  logic       fim_restore,
  output logic       zeraPosicoes,
  output logic       resetaVidas,
  output logic       contaT,
  output logic       zeraT,
  output logic       desloca,
  output logic       escolhe_modo,
  output logic       escolhe_vida,
  output logic       escolhe_mapa,
  output logic       checa_colisao,
  output logic       atualiza,
  output logic       restore,
  output logic       ganhou,
  output logic       perdeu,
  output logic [3:0] db_estado
);

  estado_t estado_atual;
  estado_t proximo_estado;
  logic    conf_p;

  // A held confirm button yields a single pulse, so it advances one menu only.
  edge_detector u_conf_edge (
    .clock (clock),
    .reset (~reset),
    .sinal (confirma),
    .pulso (conf_p)
  );

  always_ff @(posedge clock) begin
    if (!reset) estado_atual <= ST_INICIAL;
    else        estado_atual <= proximo_estado;
  end

  always_comb begin
    proximo_estado = estado_atual;
    case (estado_atual)
      ST_INICIAL:  if (iniciar)     proximo_estado = ST_RESTAURA;
      ST_RESTAURA: if (fim_restore) proximo_estado = ST_ESC_MODO;
      ST_ESC_MODO: if (conf_p)      proximo_estado = ST_ESC_VIDA;
      ST_ESC_VIDA: if (conf_p)      proximo_estado = ST_ESC_MAPA;
      ST_ESC_MAPA: if (conf_p)      proximo_estado = ST_PREPARA;
      ST_PREPARA:                   proximo_estado = ST_ESPERA;
      ST_ESPERA: begin
        // A move in the same cycle as the timer expiring still counts.
        if (borda_movimento)                    proximo_estado = ST_CHECA;
        else if (timeout && (USA_TIMEOUT != 0)) proximo_estado = ST_PERDEU;
      end
      ST_CHECA:    proximo_estado = ST_VERIFICA;
      ST_VERIFICA: begin
        if (colisao)       proximo_estado = ST_PERDEU;
        else if (fim_mapa) proximo_estado = ST_GANHOU;
        else               proximo_estado = ST_ESPERA;
      end
      ST_GANHOU:   if (conf_p) proximo_estado = ST_INICIAL;
      ST_PERDEU:   if (conf_p) proximo_estado = ST_INICIAL;
      default:     proximo_estado = ST_INICIAL;
    endcase
  end

  always_comb begin
    zeraPosicoes  = 1'b0;
    resetaVidas   = 1'b0;
    contaT        = 1'b0;
    zeraT         = 1'b0;
    desloca       = 1'b0;
    escolhe_modo  = 1'b0;
    escolhe_vida  = 1'b0;
    escolhe_mapa  = 1'b0;
    checa_colisao = 1'b0;
    atualiza      = 1'b0;
    restore       = 1'b0;
    ganhou        = 1'b0;
    perdeu        = 1'b0;
    case (estado_atual)
      ST_RESTAURA: restore      = 1'b1;
      ST_ESC_MODO: escolhe_modo = 1'b1;
      ST_ESC_VIDA: escolhe_vida = 1'b1;
      ST_ESC_MAPA: escolhe_mapa = 1'b1;
      // Keeps the chosen lives and map; only positions and timer restart.
      ST_PREPARA: begin
        zeraPosicoes = 1'b1;
        zeraT        = 1'b1;
      end
      ST_ESPERA: begin
        contaT  = 1'b1;
        desloca = 1'b1;
      end
      ST_CHECA: begin
        checa_colisao = 1'b1;
        atualiza      = 1'b1;
      end
      ST_VERIFICA: zeraT  = 1'b1;
      ST_GANHOU:   ganhou = 1'b1;
      ST_PERDEU:   perdeu = 1'b1;
      default: begin
        zeraPosicoes = 1'b1;
        resetaVidas  = 1'b1;
        zeraT        = 1'b1;
      end
    endcase
  end

  assign db_estado = estado_atual;

endmodule
